// File: rtl/cpu_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_state_sequencer
//  Purpose  : Instruction-phase FSM driving one-hot phase strobes to the decoder
//  Revision : 1.0
// ============================================================================
module cpu_state_sequencer #(
    parameter int MUL_STEPS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             MRDY,
    input  logic             f_is_D,
    input  logic             t_is_D,
    input  logic             op_MUL,
    input  logic             op_RIT,
    input  logic             op_SVC,
    input  logic             irq_pend,
    output logic             IF0,
    output logic             IF1,
    output logic             FF0,
    output logic             FF1,
    output logic             FF2,
    output logic             TF0,
    output logic             TF1,
    output logic             EX0,
    output logic             EX1,
    output logic             IT0,
    output logic             IT1,
    output logic             IT2,
    output logic             MUL1,
    output logic             MUL2_1,
    output logic             MUL2_2,
    output logic             MUL3,
    output logic             MUL4,
    output logic [CNT_W-1:0] mul_cnt,
    output logic             inst_done,
    output logic             irq_taken
);

    typedef enum logic [16:0] {
        S_IF0    = 17'd1 << 0,
        S_IF1    = 17'd1 << 1,
        S_FF0    = 17'd1 << 2,
        S_FF1    = 17'd1 << 3,
        S_FF2    = 17'd1 << 4,
        S_TF0    = 17'd1 << 5,
        S_TF1    = 17'd1 << 6,
        S_EX0    = 17'd1 << 7,
        S_EX1    = 17'd1 << 8,
        S_IT0    = 17'd1 << 9,
        S_IT1    = 17'd1 << 10,
        S_IT2    = 17'd1 << 11,
        S_MUL1   = 17'd1 << 12,
        S_MUL2_1 = 17'd1 << 13,
        S_MUL2_2 = 17'd1 << 14,
        S_MUL3   = 17'd1 << 15,
        S_MUL4   = 17'd1 << 16
    } state_t;

    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_STEPS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic             inst_done_q, inst_done_d;
    logic             irq_taken_q, irq_taken_d;
    logic             w_go_end;

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        inst_done_d = 1'b0;
        irq_taken_d = 1'b0;
        w_go_end    = 1'b0;
        case (state_q)
            S_IF0:    if (MRDY) state_d = S_IF1;
            S_IF1:    state_d = S_FF0;
            S_FF0: begin
                if (op_RIT || op_SVC)  state_d = S_IT0;
                else if (op_MUL)       state_d = S_MUL1;
                else if (f_is_D)       state_d = t_is_D ? S_EX0 : S_TF0;
                else                   state_d = S_FF1;
            end
            S_FF1:    if (MRDY) state_d = S_FF2;
            S_FF2:    state_d = t_is_D ? S_EX0 : S_TF0;
            S_TF0:    state_d = S_TF1;
            S_TF1:    if (MRDY) state_d = S_EX0;
            S_EX0: begin
                if (t_is_D) w_go_end = 1'b1;
                else        state_d  = S_EX1;
            end
            S_EX1:    if (MRDY) w_go_end = 1'b1;
            S_MUL1: begin
                state_d   = S_MUL2_1;
                mul_cnt_d = C_MUL_LOAD;
            end
            S_MUL2_1: state_d = S_MUL2_2;
            S_MUL2_2: begin
                // Saturate at zero so a corrupted count can never wrap.
                if (mul_cnt_q <= CNT_W'(1)) begin
                    mul_cnt_d = '0;
                    state_d   = S_MUL3;
                end else begin
                    mul_cnt_d = mul_cnt_q - CNT_W'(1);
                    state_d   = S_MUL2_1;
                end
            end
            S_MUL3:   if (MRDY) state_d = S_MUL4;
            S_MUL4:   if (MRDY) w_go_end = 1'b1;
            S_IT0:    state_d = S_IT1;
            S_IT1:    if (MRDY) state_d = S_IT2;
            S_IT2: begin
                if (MRDY) begin
                    state_d     = S_IF0;
                    inst_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IF0;
                mul_cnt_d = '0;
            end
        endcase

        // Instruction boundary: the only place a pending interrupt is accepted.
        if (w_go_end) begin
            inst_done_d = 1'b1;
            if (irq_pend) begin
                state_d     = S_IT0;
                irq_taken_d = 1'b1;
            end else begin
                state_d     = S_IF0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= S_IF0;
            mul_cnt_q   <= '0;
            inst_done_q <= 1'b0;
            irq_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            inst_done_q <= inst_done_d;
            irq_taken_q <= irq_taken_d;
        end
    end

    assign IF0       = state_q[0];
    assign IF1       = state_q[1];
    assign FF0       = state_q[2];
    assign FF1       = state_q[3];
    assign FF2       = state_q[4];
    assign TF0       = state_q[5];
    assign TF1       = state_q[6];
    assign EX0       = state_q[7];
    assign EX1       = state_q[8];
    assign IT0       = state_q[9];
    assign IT1       = state_q[10];
    assign IT2       = state_q[11];
    assign MUL1      = state_q[12];
    assign MUL2_1    = state_q[13];
    assign MUL2_2    = state_q[14];
    assign MUL3      = state_q[15];
    assign MUL4      = state_q[16];
    assign mul_cnt   = mul_cnt_q;
    assign inst_done = inst_done_q;
    assign irq_taken = irq_taken_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_state_sequencer
//  Purpose  : Randomized bench against a per-instruction phase-list model
//  Revision : 1.0
// ============================================================================
module tb_cpu_state_sequencer;

    localparam int MUL_STEPS = 16;
    localparam int CNT_W     = 5;

    localparam int P_IF0 = 0,  P_IF1 = 1,  P_FF0 = 2,  P_FF1 = 3,  P_FF2 = 4;
    localparam int P_TF0 = 5,  P_TF1 = 6,  P_EX0 = 7,  P_EX1 = 8,  P_IT0 = 9;
    localparam int P_IT1 = 10, P_IT2 = 11, P_MUL1 = 12, P_M21 = 13, P_M22 = 14;
    localparam int P_MUL3 = 15, P_MUL4 = 16;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic CLR = 1'b1, MRDY = 1'b1, irq_pend = 1'b0;
    logic f_is_D = 1'b0, t_is_D = 1'b0, op_MUL = 1'b0, op_RIT = 1'b0, op_SVC = 1'b0;
    logic IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2;
    logic MUL1, MUL2_1, MUL2_2, MUL3, MUL4, inst_done, irq_taken;
    logic [CNT_W-1:0] mul_cnt;
    logic [16:0] strobes;

    assign strobes = {MUL4, MUL3, MUL2_2, MUL2_1, MUL1, IT2, IT1, IT0,
                      EX1, EX0, TF1, TF0, FF2, FF1, FF0, IF1, IF0};

    cpu_state_sequencer #(.MUL_STEPS(MUL_STEPS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .CLR(CLR), .MRDY(MRDY),
        .f_is_D(f_is_D), .t_is_D(t_is_D), .op_MUL(op_MUL), .op_RIT(op_RIT),
        .op_SVC(op_SVC), .irq_pend(irq_pend),
        .IF0(IF0), .IF1(IF1), .FF0(FF0), .FF1(FF1), .FF2(FF2),
        .TF0(TF0), .TF1(TF1), .EX0(EX0), .EX1(EX1),
        .IT0(IT0), .IT1(IT1), .IT2(IT2),
        .MUL1(MUL1), .MUL2_1(MUL2_1), .MUL2_2(MUL2_2), .MUL3(MUL3), .MUL4(MUL4),
        .mul_cnt(mul_cnt), .inst_done(inst_done), .irq_taken(irq_taken)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: current phase plus the list of phases still to come in this instruction.
    int cur = P_IF0;
    int q[$];
    int exp_cnt = 0;
    bit exp_done = 1'b0, exp_taken = 1'b0;
    int force_cls = -1;
    bit pf, pt, pm, pr, ps;

    function automatic bit is_mem(input int p);
        return p inside {P_IF0, P_FF1, P_TF1, P_EX1, P_IT1, P_IT2, P_MUL3, P_MUL4};
    endfunction

    function automatic void new_instr();
        int cls;
        cls = (force_cls >= 0) ? force_cls : int'($urandom_range(0, 6));
        pf = 1'($urandom_range(0, 1));
        pt = 1'($urandom_range(0, 1));
        pm = 1'b0; pr = 1'b0; ps = 1'b0;
        case (cls)
            0: begin pf = 1'b1; pt = 1'b1; end
            1: begin pf = 1'b0; pt = 1'b0; end
            2: begin pf = 1'b1; pt = 1'b0; end
            3: begin pf = 1'b0; pt = 1'b1; end
            4: pm = 1'b1;
            5: begin ps = 1'b1; pm = 1'($urandom_range(0, 1)); pr = 1'($urandom_range(0, 1)); end
            default: begin pr = 1'b1; pm = 1'($urandom_range(0, 1)); end
        endcase
        q.delete();
        q.push_back(P_IF1);
        q.push_back(P_FF0);
        if (pr || ps) begin
            q.push_back(P_IT0); q.push_back(P_IT1); q.push_back(P_IT2);
        end else if (pm) begin
            q.push_back(P_MUL1);
            for (int i = 0; i < MUL_STEPS; i++) begin
                q.push_back(P_M21); q.push_back(P_M22);
            end
            q.push_back(P_MUL3); q.push_back(P_MUL4);
        end else begin
            if (!pf) begin q.push_back(P_FF1); q.push_back(P_FF2); end
            if (pt) q.push_back(P_EX0);
            else begin
                q.push_back(P_TF0); q.push_back(P_TF1); q.push_back(P_EX0); q.push_back(P_EX1);
            end
        end
    endfunction

    task automatic cycle(input bit clr, input bit mrdy, input bit irq);
        bit fresh;
        fresh = 1'b0;
        CLR = clr; MRDY = mrdy; irq_pend = irq;
        if (clr) begin
            cur = P_IF0; exp_cnt = 0; exp_done = 1'b0; exp_taken = 1'b0;
            new_instr(); fresh = 1'b1;
        end else if (is_mem(cur) && !mrdy) begin
            exp_done = 1'b0; exp_taken = 1'b0;
        end else begin
            exp_done = 1'b0; exp_taken = 1'b0;
            if (cur == P_MUL1) exp_cnt = MUL_STEPS;
            if (cur == P_M22 && exp_cnt > 0) exp_cnt--;
            if (q.size() > 0) cur = q.pop_front();
            else begin
                exp_done = 1'b1;
                if (cur != P_IT2 && irq) begin
                    cur = P_IT0; exp_taken = 1'b1;
                    q.delete(); q.push_back(P_IT1); q.push_back(P_IT2);
                end else begin
                    cur = P_IF0; new_instr(); fresh = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
        // New decoder classification is applied only after the boundary edge.
        if (fresh) begin
            f_is_D = pf; t_is_D = pt; op_MUL = pm; op_RIT = pr; op_SVC = ps;
        end
        chk_eq("phase", 32'(strobes), 32'd1 << cur);
        chk_eq("mul_cnt", 32'(mul_cnt), exp_cnt);
        chk_eq("inst_done", 32'(inst_done), 32'(exp_done));
        chk_eq("irq_taken", 32'(irq_taken), 32'(exp_taken));
    endtask

    task automatic run_until(input int ph, input int cnt_req);
        for (int i = 0; i < 200 && !(cur == ph && (cnt_req < 0 || exp_cnt == cnt_req)); i++)
            cycle(1'b0, 1'b1, 1'b0);
        chk_eq("reach_phase", 32'(strobes), 32'd1 << ph);
    endtask

    initial begin
        force_cls = 0;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (12) cycle(1'b0, 1'b1, 1'b0);

        force_cls = 1;
        cycle(1'b1, 1'b1, 1'b0);
        run_until(P_FF1, -1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b1, 1'b0);

        force_cls = 4;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (45) cycle(1'b0, 1'b1, 1'b0);

        force_cls = 0;
        cycle(1'b1, 1'b1, 1'b0);
        run_until(P_EX0, -1);
        repeat (6) cycle(1'b0, 1'b1, 1'b1);

        force_cls = 5;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (14) cycle(1'b0, 1'b1, 1'b1);

        force_cls = 4;
        cycle(1'b1, 1'b1, 1'b0);
        run_until(P_M22, 7);
        cycle(1'b1, 1'b1, 1'b0);

        force_cls = 1;
        cycle(1'b1, 1'b1, 1'b0);
        run_until(P_FF1, -1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        force_cls = -1;
        repeat (4000)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
